// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch funct3 codes, ALU compare opcodes and
// the memory/writeback control bundle carried across the EX/MEM boundary.
package pipe_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [3:0] EQUAL = 4'b1000;
    localparam logic [3:0] LESS  = 4'b1100;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    // The ALU already computed Equal or Less; the branch only picks a polarity.
    function automatic logic branch_cond(input logic [2:0] funct3, input logic result_lsb);
        logic cond;
        case (funct3)
            BEQ, BLT, BLTU: cond = result_lsb;
            BNE, BGE, BGEU: cond = ~result_lsb;
            default:        cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow resolution: decides whether the EX instruction
// changes the PC and where it goes.
module branch_resolve
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic [2:0]            funct3,
    input  logic                  result_lsb,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  jal,
    input  logic                  jalr,
    input  logic                  branch,
    output logic                  take,
    output logic [PC_WIDTH-1:0]   target
);

    logic [PC_WIDTH-1:0] imm_pc;
    logic [PC_WIDTH-1:0] jalr_pc;

    assign imm_pc  = PC_WIDTH'($signed(imm));
    assign jalr_pc = PC_WIDTH'(alu_result) & ~PC_WIDTH'(1);

    assign take   = jal | jalr | (branch & branch_cond(funct3, result_lsb));
    assign target = jalr ? jalr_pc : (pc + imm_pc);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution and a single-shot
// PC redirect that fires once even if the taken instruction sits under stall.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_rs2_data,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_imm,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_branch,
    input  logic                  ex_jal,
    input  logic                  ex_jalr,
    input  logic [2:0]            ex_funct3,
    output logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] mem_result,
    output logic [DATA_WIDTH-1:0] mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic                  pc_redirect,
    output logic [PC_WIDTH-1:0]   pc_target,
    output logic                  flush_younger
);

    logic                  ev;
    logic                  take;
    logic [PC_WIDTH-1:0]   target;
    logic [PC_WIDTH-1:0]   link_pc;
    logic [DATA_WIDTH-1:0] result_next;
    ex_mem_ctrl_t          ctrl_next;

    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [DATA_WIDTH-1:0] store_data_reg;
    logic [REG_ADDR_W-1:0] rd_reg;
    ex_mem_ctrl_t          ctrl_reg;
    logic                  redirect_done_reg;

    assign ev = ex_valid & ~flush;

    branch_resolve #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_branch_resolve (
        .funct3     (ex_funct3),
        .result_lsb (ex_alu_result[0]),
        .pc         (ex_pc),
        .imm        (ex_imm),
        .alu_result (ex_alu_result),
        .jal        (ex_jal),
        .jalr       (ex_jalr),
        .branch     (ex_branch),
        .take       (take),
        .target     (target)
    );

    // Reset gates the redirect directly so it is quiet regardless of EX inputs.
    assign pc_redirect   = ev & take & ~redirect_done_reg & ~reset;
    assign pc_target     = target;
    assign flush_younger = pc_redirect;

    assign link_pc     = ex_pc + PC_WIDTH'(4);
    assign result_next = (ex_jal | ex_jalr) ? DATA_WIDTH'(link_pc) : ex_alu_result;

    // Bubbles carry no write enables, so downstream never needs to check valid.
    always_comb begin
        ctrl_next            = '0;
        ctrl_next.reg_write  = ex_reg_write & ev;
        ctrl_next.mem_read   = ex_mem_read & ev;
        ctrl_next.mem_write  = ex_mem_write & ev;
        ctrl_next.mem_to_reg = ex_mem_to_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            result_reg     <= '0;
            store_data_reg <= '0;
            rd_reg         <= '0;
            ctrl_reg       <= '0;
        end else if (!stall) begin
            valid_reg      <= ev;
            result_reg     <= result_next;
            store_data_reg <= ex_rs2_data;
            rd_reg         <= ex_rd;
            ctrl_reg       <= ctrl_next;
        end
    end

    // Remembers that the held EX instruction already redirected; forgotten once EX moves on.
    always_ff @(posedge clk) begin
        if (reset || !stall) begin
            redirect_done_reg <= 1'b0;
        end else if (pc_redirect) begin
            redirect_done_reg <= 1'b1;
        end
    end

    assign mem_valid      = valid_reg;
    assign mem_result     = result_reg;
    assign mem_store_data = store_data_reg;
    assign mem_rd         = rd_reg;
    assign mem_reg_write  = ctrl_reg.reg_write;
    assign mem_mem_read   = ctrl_reg.mem_read;
    assign mem_mem_write  = ctrl_reg.mem_write;
    assign mem_mem_to_reg = ctrl_reg.mem_to_reg;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage directly downstream of the ALU. It registers the ALU result and the control/data fields of the executing instruction into the EX/MEM boundary. It resolves conditional branches and jumps from the ALU's compare result and drives a single-shot PC redirect with a younger-stage flush. It honours stall and flush from the hazard unit, with a valid bit per stage.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- PC_WIDTH, 32, program counter width
- REG_ADDR_W, 5, register index width

Ports (all synchronous to `clk`; `reset` is synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold EX and EX/MEM contents
- flush  in  1  kill the EX instruction (becomes bubble)
- ex_valid  in  1  EX holds a real instruction
- ex_alu_result  in  DATA_WIDTH  ALUResult from the ALU
- ex_rs2_data  in  DATA_WIDTH  store data
- ex_pc  in  PC_WIDTH  PC of EX instruction
- ex_imm  in  DATA_WIDTH  sign-extended immediate
- ex_rd  in  REG_ADDR_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  in  1 each  control
- ex_branch, ex_jal, ex_jalr  in  1 each  control-flow class
- ex_funct3  in  3  branch condition
- mem_valid  out  1  EX/MEM holds a real instruction
- mem_result  out  DATA_WIDTH  ALU result, or link value for jumps
- mem_store_data  out  DATA_WIDTH  registered rs2 data
- mem_rd  out  REG_ADDR_W
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each
- pc_redirect  out  1  combinational; take pc_target next cycle
- pc_target  out  PC_WIDTH  redirect address
- flush_younger  out  1  equals pc_redirect; kills IF/ID

## Operation
- Effective EX valid: ev = ex_valid & ~flush.
- Branch condition uses ALU bit 0. The ALU is driven with Equal for BEQ/BNE and Less for BLT/BGE/BLTU/BGEU.
  - funct3 000: taken if result[0]=1.
  - 001: taken if result[0]=0.
  - 100/110: taken if result[0]=1.
  - 101/111: taken if result[0]=0.
  - 010/011: never taken.
- Targets:
  - Branch and JAL: ex_pc + ex_imm, wrap modulo 2^PC_WIDTH.
  - JALR: ex_alu_result with bit 0 cleared.
- take = ev & (ex_jal | ex_jalr | (ex_branch & cond)).
- pc_redirect = take & ~redirect_done.
- redirect_done is internal state:
  - Set when pc_redirect fires while stall=1.
  - Cleared whenever EX advances (stall=0) or on reset.
  - A stalled taken branch therefore redirects exactly once.
- mem_result for JAL/JALR is ex_pc + 4, zero-extended or truncated to DATA_WIDTH. Otherwise it is ex_alu_result.
- Register update priority: reset > stall > normal.
  - On stall, all mem_* outputs hold.
  - Normal: mem_valid <= ev, and the data/control fields load.
  - When ev=0, the write-enable controls load as 0: mem_reg_write, mem_mem_read, mem_mem_write.
- Bubbles never write: mem_reg_write=0 and mem_mem_write=0 whenever mem_valid=0.

## Timing
- Reset values:
  - mem_valid, all mem_* control bits, and redirect_done are 0.
  - mem_result, mem_store_data and mem_rd are 0.
  - pc_redirect=0 during reset regardless of inputs.
- Latency: one cycle from EX to mem_* outputs. Redirect is same-cycle combinational from EX inputs.
- Simultaneous flush and stall: flush masks pc_redirect in that cycle and the registers hold. This is legal.
- A redirect with stall=0: redirect_done stays 0, and the next EX instruction is evaluated fresh.
- Reset mid-stall clears redirect_done and bubbles EX/MEM.
- No combinational path from any mem_* output to any input.

## Structure
- Shared package `pipe_pkg`:
  - funct3 branch constants: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ALU opcode constants: EQUAL = 4'b1000, LESS = 4'b1100.
  - packed struct `ex_mem_ctrl_t` holding the four memory/writeback control bits.
- One sub-module: `branch_resolve`, combinational. Inputs are funct3, result[0], pc, imm, alu_result, and the jal/jalr/branch flags. Outputs are take and target.
- Registers and redirect_done stay in `ex_mem_stage`.

## Test plan
- Reset held 2 cycles with random inputs -> all mem_* = 0, pc_redirect = 0.
- ADD result 0x0000_0010, rd=5, reg_write=1, no stall -> next cycle mem_valid=1, mem_result=0x10, mem_rd=5.
- BEQ, result=1, pc=0x100, imm=0x20 -> pc_redirect=1 and pc_target=0x120 same cycle. With result=0, BNE redirects and BEQ does not.
- JALR, result=0x0000_0203, pc=0x40 -> pc_target=0x202, next cycle mem_result=0x44.
- Taken BLT held under stall for 3 cycles -> pc_redirect high only in the first cycle, mem_* unchanged. On release, a following taken branch redirects again.
- flush=1 with a taken JAL and reg_write=1 -> pc_redirect=0, next cycle mem_valid=0 and mem_reg_write=0.
